ir_err_compute: RTL
===================

Name: ir_err_compute

Overview:
- Producer side of the err_sat/err_vld interface consumed by the integrator (I_term) and the rest of the PID path.
- Sequences 8 line-sensor A2D conversions (channels 0..7) through a start/complete handshake.
- Forms a signed weighted left-minus-right error, scales and saturates it to 10 bits, and presents it with a one-cycle err_vld pulse.
- Sits between the A2D interface block and the PID terms.

Parameters:
- SHFT, 3, arithmetic right-shift applied to the raw accumulator before saturation.
- TIMEOUT, 1023, max cycles spent waiting for cnv_cmplt before the sequence aborts.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- go  input  1  start one 8-channel sequence; sampled only in IDLE
- strt_cnv  output  1  registered one-cycle pulse requesting a conversion on chnnl
- chnnl  output  3  channel being converted; stable from the strt_cnv cycle through its cnv_cmplt
- cnv_cmplt  input  1  conversion done; res valid in the same cycle
- res  input  12  unsigned conversion result
- err_sat  output  10  signed saturated error; holds its value between updates
- err_vld  output  1  one-cycle pulse; err_sat is new in that cycle
- err_fault  output  1  one-cycle pulse on timeout abort
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, strt_cnv=0, chnnl=0, err_sat=0, err_vld=0, err_fault=0, busy=0, accumulator=0, timeout counter=0.
- Reset asserted mid-sequence aborts it immediately; no err_vld or err_fault is produced.
- FSM states: IDLE, CNV, WAIT, DONE.
- IDLE:
  - go=1 at an edge: accumulator cleared, chnnl=0, go to CNV.
  - go in any other state is ignored (no queuing).
- CNV:
  - strt_cnv=1 for exactly this one cycle.
  - Timeout counter cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle cnv_cmplt=0.
  - cnv_cmplt=1 at an edge: accumulator += weight(chnnl) * res.
    - If chnnl<7: chnnl increments, next state CNV, so the next strt_cnv comes 1 cycle after cnv_cmplt.
    - If chnnl=7: next state DONE.
  - cnv_cmplt outside WAIT is ignored.
  - If cnv_cmplt=1 in the same cycle the counter reaches TIMEOUT, cnv_cmplt wins.
  - Counter reaches TIMEOUT with no cnv_cmplt:
    - err_fault pulses 1 cycle; state returns to IDLE.
    - Partial accumulator is discarded; err_sat keeps its previous value; err_vld stays 0.
    - The next go restarts at channel 0.
- Weights: pair p = chnnl>>1; magnitude 1<<p (1, 2, 4, 8); positive for even channels (left), negative for odd channels (right).
- Accumulator: 17-bit signed, no overflow possible; range ±61425.
- DONE (single cycle):
  - scaled = accumulator >>> SHFT (arithmetic, rounds toward -inf).
  - Saturation: err_sat = 511 if scaled>511, -512 if scaled<-512, else scaled[9:0].
  - err_sat and err_vld=1 are registered at the DONE edge and are visible the cycle after DONE.
  - err_vld drops the next cycle; state returns to IDLE.
- Latency: the last cnv_cmplt sample edge is edge k; DONE occupies cycle k..k+1; err_sat and err_vld update at edge k+1.
- go held continuously yields back-to-back sequences with 1 IDLE cycle between them.

Test Plan:
- Bench A2D model answers cnv_cmplt 4 cycles after strt_cnv; all res=0x100; pulse go -> exactly 8 strt_cnv pulses with chnnl 0..7 in order, err_sat=10'h000, exactly one err_vld pulse, busy low afterwards.
- ch6 res=0x0FF, all other channels 0 -> accumulator 2040, err_sat=10'h0FF (255).
- Even channels 0xFFF, odd channels 0 -> accumulator 61425, scaled 7678, err_sat=10'h1FF (+511). Mirror case, odd channels 0xFFF and even 0 -> scaled -7679, err_sat=10'h200 (-512).
- Prior err_sat=10'h0FF; withhold cnv_cmplt on ch3 for TIMEOUT cycles -> err_fault pulses once, no err_vld, err_sat stays 10'h0FF, busy drops. Next go -> chnnl starts at 0 and a full sequence completes.
- Assert go repeatedly during a sequence -> no extra strt_cnv, channel order unchanged, one err_vld.
- Assert rst during WAIT on ch5 -> all outputs 0 immediately. After rst release and go -> a clean sequence from ch0 produces the correct err_sat.

Source files
------------

// File: rtl/ir_err_compute.sv
// rtl/ir_err_compute.sv - sequences 8 line-sensor conversions into a saturated signed error
module ir_err_compute #(
  parameter int SHFT    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [9:0]  err_sat,
  output logic        err_vld,
  output logic        err_fault,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CNV, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           chnnl_q, chnnl_d;
  logic signed [16:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 strt_cnv_q, strt_cnv_d;
  logic [9:0]           err_sat_q, err_sat_d;
  logic                 err_vld_q, err_vld_d;
  logic                 err_fault_q, err_fault_d;
  logic                 busy_q, busy_d;

  logic [16:0]          mag;
  logic signed [16:0]   term;
  logic signed [16:0]   scaled;

  // Even channels sit on the left and add, odd channels on the right and subtract.
  always_comb begin
    mag    = {5'd0, res} << chnnl_q[2:1];
    term   = chnnl_q[0] ? -$signed(mag) : $signed(mag);
    scaled = acc_q >>> SHFT;
  end

  always_comb begin
    state_d     = state_q;
    chnnl_d     = chnnl_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    strt_cnv_d  = 1'b0;
    err_sat_d   = err_sat_q;
    err_vld_d   = 1'b0;
    err_fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          acc_d      = '0;
          chnnl_d    = 3'd0;
          strt_cnv_d = 1'b1;
          state_d    = CNV;
        end
      end
      CNV: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving on the timeout cycle still counts.
        if (cnv_cmplt) begin
          acc_d = acc_q + term;
          if (chnnl_q == 3'd7) begin
            state_d = DONE;
          end else begin
            chnnl_d    = chnnl_q + 3'd1;
            strt_cnv_d = 1'b1;
            state_d    = CNV;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          acc_d       = '0;
          err_fault_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (scaled > 17'sd511)       err_sat_d = 10'h1FF;
        else if (scaled < -17'sd512) err_sat_d = 10'h200;
        else                         err_sat_d = scaled[9:0];
        err_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      chnnl_q     <= 3'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      strt_cnv_q  <= 1'b0;
      err_sat_q   <= 10'd0;
      err_vld_q   <= 1'b0;
      err_fault_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chnnl_q     <= chnnl_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      strt_cnv_q  <= strt_cnv_d;
      err_sat_q   <= err_sat_d;
      err_vld_q   <= err_vld_d;
      err_fault_q <= err_fault_d;
      busy_q      <= busy_d;
    end
  end

  assign strt_cnv  = strt_cnv_q;
  assign chnnl     = chnnl_q;
  assign err_sat   = err_sat_q;
  assign err_vld   = err_vld_q;
  assign err_fault = err_fault_q;
  assign busy      = busy_q;

endmodule
